// File: rtl/cpu_regs_wb_arbiter_if.sv
// Purpose: bundles the writeback arbiter's request and response signals.
// Ports (signals):
//   alu_valid/alu_rd/alu_d : ALU writeback request; it has no backpressure.
//   mem_valid/mem_rd/mem_d : load writeback request, accepted when mem_ready=1.
//   mem_ready              : combinational load acceptance.
//   rd/d                   : registered cpu_regs write port (rd=0 means no write).
//   stall_req              : pipeline stall while an ALU entry is held.
//   proto_err              : sticky flag for an ALU request that arrived during a stall.
// Modports: master drives the requests; slave is the arbiter.
interface cpu_regs_wb_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             alu_valid;
  logic [4:0]       alu_rd;
  logic [WIDTH-1:0] alu_d;
  logic             mem_valid;
  logic [4:0]       mem_rd;
  logic [WIDTH-1:0] mem_d;
  logic             mem_ready;
  logic [4:0]       rd;
  logic [WIDTH-1:0] d;
  logic             stall_req;
  logic             proto_err;

  modport master (
    output alu_valid, alu_rd, alu_d, mem_valid, mem_rd, mem_d,
    input  mem_ready, rd, d, stall_req, proto_err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_d, mem_valid, mem_rd, mem_d,
    output mem_ready, rd, d, stall_req, proto_err
  );
endinterface

// File: rtl/cpu_regs_wb_arbiter.sv
// Purpose: merges ALU and load writebacks onto the single cpu_regs write port.
// The ALU cannot be backpressured, so a losing ALU request is parked in a
// one-entry hold buffer and the pipeline is stalled. A waiting load wins after
// STARVE_MAX consecutive denied cycles.
// Ports:
//   clk   : clock, rising edge.
//   n_rst : asynchronous active-low reset.
//   wb    : slave side of cpu_regs_wb_arbiter_if (requests in, write port out).
module cpu_regs_wb_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input logic                  clk,
  input logic                  n_rst,
  cpu_regs_wb_arbiter_if.slave wb
);

  localparam int unsigned RD_W  = 5;
  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic             hold_valid_q, hold_valid_d;
  logic [RD_W-1:0]  hold_rd_q,    hold_rd_d;
  logic [WIDTH-1:0] hold_d_q,     hold_d_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [RD_W-1:0]  rd_q,         rd_d;
  logic [WIDTH-1:0] d_q,          d_d;
  logic             proto_err_q,  proto_err_d;

  logic alu_req;
  logic mem_req;
  logic force_mem;
  logic grant_hold;
  logic grant_alu;
  logic grant_mem;
  logic mem_ready_int;

  // Grant selection and next-state computation.
  always_comb begin
    hold_valid_d  = hold_valid_q;
    hold_rd_d     = hold_rd_q;
    hold_d_d      = hold_d_q;
    starve_cnt_d  = starve_cnt_q;
    rd_d          = '0;
    d_d           = d_q;
    proto_err_d   = proto_err_q;
    grant_hold    = 1'b0;
    grant_alu     = 1'b0;
    grant_mem     = 1'b0;

    // rd=0 requests are no-ops; an ALU request during a hold is dropped.
    alu_req   = wb.alu_valid && !hold_valid_q && (wb.alu_rd != '0);
    mem_req   = wb.mem_valid && (wb.mem_rd != '0);
    force_mem = wb.mem_valid && (starve_cnt_q == CNT_W'(STARVE_MAX));

    if (force_mem && mem_req) begin
      grant_mem = 1'b1;
    end else if (hold_valid_q) begin
      grant_hold = 1'b1;
    end else if (alu_req) begin
      grant_alu = 1'b1;
    end else if (mem_req) begin
      grant_mem = 1'b1;
    end

    mem_ready_int = wb.mem_valid && (grant_mem || (wb.mem_rd == '0));

    if (grant_hold) begin
      rd_d         = hold_rd_q;
      d_d          = hold_d_q;
      hold_valid_d = 1'b0;
    end else if (grant_alu) begin
      rd_d = wb.alu_rd;
      d_d  = wb.alu_d;
    end else if (grant_mem) begin
      rd_d = wb.mem_rd;
      d_d  = wb.mem_d;
    end

    // A live ALU request can only lose to a forced load; park it.
    if (alu_req && !grant_alu) begin
      hold_valid_d = 1'b1;
      hold_rd_d    = wb.alu_rd;
      hold_d_d     = wb.alu_d;
    end

    if (wb.alu_valid && hold_valid_q) begin
      proto_err_d = 1'b1;
    end

    // Count consecutive denied load cycles, saturating.
    if (wb.mem_valid && !mem_ready_int) begin
      if (starve_cnt_q != CNT_W'(STARVE_MAX)) begin
        starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
    end else begin
      starve_cnt_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold_valid_q <= 1'b0;
      hold_rd_q    <= '0;
      hold_d_q     <= '0;
      starve_cnt_q <= '0;
      rd_q         <= '0;
      d_q          <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_rd_q    <= hold_rd_d;
      hold_d_q     <= hold_d_d;
      starve_cnt_q <= starve_cnt_d;
      rd_q         <= rd_d;
      d_q          <= d_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // mem_ready is forced low during reset so no load is accepted then.
  assign wb.mem_ready = mem_ready_int && n_rst;
  assign wb.rd        = rd_q;
  assign wb.d         = d_q;
  assign wb.stall_req = hold_valid_q;
  assign wb.proto_err = proto_err_q;

endmodule

// File: tb/tb_cpu_regs_wb_arbiter.sv
// Purpose: self-checking bench for cpu_regs_wb_arbiter; directed scenarios
// followed by randomized traffic, compared against a behavioural model.
module tb_cpu_regs_wb_arbiter;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned STARVE_MAX = 3;

  logic clk;
  logic n_rst;

  cpu_regs_wb_arbiter_if #(.WIDTH(WIDTH)) bus ();

  cpu_regs_wb_arbiter #(
    .WIDTH      (WIDTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .wb    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  bit          m_hold;
  logic [4:0]  m_hold_rd;
  logic [31:0] m_hold_d;
  int          m_starve;
  logic [4:0]  m_rd;
  logic [31:0] m_d;
  bit          m_proto;
  bit          obs_ready;
  bit          last_ready;

  // Random-phase source state
  bit          pm_v;
  logic [4:0]  pm_rd;
  logic [31:0] pm_d;
  bit          r_av;
  logic [4:0]  r_ar;
  logic [31:0] r_ad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hold    = 1'b0;
    m_hold_rd = '0;
    m_hold_d  = '0;
    m_starve  = 0;
    m_rd      = '0;
    m_d       = '0;
    m_proto   = 1'b0;
    last_ready = 1'b0;
  endtask

  task automatic check_outputs();
    chk("rd",        32'(bus.rd),        32'(m_rd));
    chk("d",         bus.d,              m_d);
    chk("stall_req", 32'(bus.stall_req), 32'(m_hold));
    chk("proto_err", 32'(bus.proto_err), 32'(m_proto));
  endtask

  // One clock cycle: drive requests, check mem_ready, advance the model, check outputs.
  task automatic step(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                      input bit mv, input logic [4:0] mr, input logic [31:0] md);
    int winner;  // 0 none, 1 held entry, 2 ALU, 3 load
    bit alu_real;
    bit mem_real;
    bit exp_ready;
    bus.alu_valid = av;
    bus.alu_rd    = ar;
    bus.alu_d     = ad;
    bus.mem_valid = mv;
    bus.mem_rd    = mr;
    bus.mem_d     = md;
    #1;
    alu_real = av && !m_hold && (ar != 5'd0);
    mem_real = mv && (mr != 5'd0);
    if (mem_real && m_starve >= int'(STARVE_MAX)) winner = 3;
    else if (m_hold)                              winner = 1;
    else if (alu_real)                            winner = 2;
    else if (mem_real)                            winner = 3;
    else                                          winner = 0;
    exp_ready = mv && ((mr == 5'd0) || (winner == 3));
    obs_ready = bus.mem_ready;
    chk("mem_ready", 32'(bus.mem_ready), 32'(exp_ready));

    if (av && m_hold) m_proto = 1'b1;
    case (winner)
      1: begin m_rd = m_hold_rd; m_d = m_hold_d; m_hold = 1'b0; end
      2: begin m_rd = ar; m_d = ad; end
      3: begin m_rd = mr; m_d = md; end
      default: m_rd = 5'd0;
    endcase
    if (alu_real && winner != 2) begin
      m_hold    = 1'b1;
      m_hold_rd = ar;
      m_hold_d  = ad;
    end
    if (mv && !exp_ready) m_starve = (m_starve < int'(STARVE_MAX)) ? m_starve + 1 : int'(STARVE_MAX);
    else                  m_starve = 0;
    last_ready = exp_ready;

    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Asynchronous reset pulse between edges, with a load presented throughout.
  task automatic pulse_reset();
    bus.alu_valid = 1'b0;
    bus.alu_rd    = 5'd0;
    bus.alu_d     = 32'd0;
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd5;
    bus.mem_d     = 32'h5;
    n_rst = 1'b0;
    #1;
    chk("rst_rd",        32'(bus.rd),        32'd0);
    chk("rst_d",         bus.d,              32'd0);
    chk("rst_stall",     32'(bus.stall_req), 32'd0);
    chk("rst_proto",     32'(bus.proto_err), 32'd0);
    chk("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
    model_reset();
    bus.mem_valid = 1'b0;
    bus.mem_rd    = 5'd0;
    #1;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Three denied load cycles, then the forced grant parks the ALU request.
  task automatic starve_into_hold(input logic [4:0] mrd, input logic [4:0] hold_rd);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 5'(20 + k), 32'(32'h200 + k), 1'b1, mrd, 32'h55);
      chk("starve_denied", 32'(obs_ready), 32'd0);
    end
    step(1'b1, hold_rd, 32'h104, 1'b1, mrd, 32'h55);
    chk("forced_ready", 32'(obs_ready), 32'd1);
    chk("forced_rd",    32'(bus.rd), 32'(mrd));
    chk("forced_stall", 32'(bus.stall_req), 32'd1);
  endtask

  initial begin
    bus.alu_valid = 1'b0;
    bus.alu_rd    = 5'd0;
    bus.alu_d     = 32'd0;
    bus.mem_valid = 1'b0;
    bus.mem_rd    = 5'd0;
    bus.mem_d     = 32'd0;
    model_reset();
    pm_v = 1'b0;
    n_rst = 1'b1;
    #1;
    pulse_reset();

    // ALU only
    step(1'b1, 5'd7, 32'hAF, 1'b0, 5'd0, 32'd0);
    chk("alu_only_rd", 32'(bus.rd), 32'd7);
    chk("alu_only_d",  bus.d, 32'hAF);
    idle();
    chk("alu_only_rd_clear", 32'(bus.rd), 32'd0);
    chk("alu_only_d_keep",   bus.d, 32'hAF);

    // ALU and load together: ALU first, load next
    step(1'b1, 5'd7, 32'hFF, 1'b1, 5'd8, 32'h11);
    chk("both_ready0", 32'(obs_ready), 32'd0);
    chk("both_rd_alu", 32'(bus.rd), 32'd7);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h11);
    chk("both_ready1", 32'(obs_ready), 32'd1);
    chk("both_rd_mem", 32'(bus.rd), 32'd8);
    chk("both_d_mem",  bus.d, 32'h11);
    idle();

    // Starvation, then the held entry drains
    starve_into_hold(5'd9, 5'd4);
    idle();
    chk("held_rd",    32'(bus.rd), 32'd4);
    chk("held_d",     bus.d, 32'h104);
    chk("held_stall", 32'(bus.stall_req), 32'd0);

    // Zero-destination load
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h77);
    chk("zero_ready", 32'(obs_ready), 32'd1);
    chk("zero_rd",    32'(bus.rd), 32'd0);
    chk("zero_stall", 32'(bus.stall_req), 32'd0);

    // Same destination from both sources: two writes in order
    step(1'b1, 5'd6, 32'h1, 1'b1, 5'd6, 32'h2);
    chk("same_rd_first_d", bus.d, 32'h1);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h2);
    chk("same_rd_second_rd", 32'(bus.rd), 32'd6);
    chk("same_rd_second_d",  bus.d, 32'h2);
    idle();

    // Protocol error during a stall, then reset clears everything
    starve_into_hold(5'd10, 5'd11);
    step(1'b1, 5'd12, 32'hBAD, 1'b0, 5'd0, 32'd0);
    chk("proto_set",    32'(bus.proto_err), 32'd1);
    chk("proto_rd",     32'(bus.rd), 32'd11);
    idle();
    chk("proto_dropped", 32'(bus.rd), 32'd0);
    chk("proto_sticky",  32'(bus.proto_err), 32'd1);
    pulse_reset();

    // Reset while an entry is held discards it
    starve_into_hold(5'd14, 5'd13);
    pulse_reset();
    idle();
    chk("no_held_write", 32'(bus.rd), 32'd0);
    idle();

    // Randomized traffic obeying the handshake and stall rules
    last_ready = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!pm_v || last_ready) begin
        pm_v  = ($urandom_range(0, 9) < 6);
        pm_rd = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 7) == 0) pm_rd = 5'd0;
        pm_d  = $urandom;
      end
      r_av = !m_hold && ($urandom_range(0, 9) < 6);
      r_ar = ($urandom_range(0, 4) == 0) ? pm_rd : 5'($urandom_range(0, 31));
      r_ad = $urandom;
      step(r_av, r_ar, r_ad, pm_v, pm_rd, pm_d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
